lvt_mpram: RTL and testbench
============================

# lvt_mpram

Parametrised multiported RAM with NW write ports and NR read ports. It is built from NW×NR simple-dual-port bank replicas and a Live Value Table (LVT) that steers each read port to the bank holding the most recent write. It is the generalised successor of our fixed 2W/1R LVT memory, and adds the following:
- configurable width, depth and port counts;
- deterministic write-conflict priority;
- a post-reset hardware initialisation sweep;
- per-port read-valid tracking.

## Interface
Parameters:
- DATA_W, 32, data width per port
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W
- NW, 2, number of write ports (≥1)
- NR, 2, number of read ports (≥1)

Ports (port i occupies bits [i*W +: W] of each flattened vector):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- busy  out  1  initialisation sweep in progress; all requests ignored while high
- wr_en  in  NW  per-port write enable
- wr_addr  in  NW*ADDR_W  write addresses
- wr_data  in  NW*DATA_W  write data
- rd_en  in  NR  per-port read enable
- rd_addr  in  NR*ADDR_W  read addresses
- rd_data  out  NR*DATA_W  registered read data
- rd_valid  out  NR  rd_data of port i updated by the previous edge

## Operation
- **Banks.** Write port w drives NR replicas: bank[w][r] for r = 0..NR-1. Every replica of write port w is written on every accepted write of port w. Read port r reads bank[w][r] for all w in parallel.
- **LVT.** The LVT has DEPTH entries, each LVT_W = max(1, clog2(NW)) bits wide. An accepted write on port w sets LVT[wr_addr_w] = w. Read port r selects bank[LVT[rd_addr_r]][r].
- **Write conflicts.** When several ports write the same address in one cycle, the highest-index port wins the LVT entry. The losing ports' banks are still written, but those banks become unreachable for that address.
- **State machine.** States are INIT and RUN. Reset enters INIT with init_cnt = 0 and busy = 1.
  - In INIT, each edge writes zero to bank[0][*][init_cnt], writes 0 to LVT[init_cnt], then increments init_cnt.
  - On the edge where init_cnt == DEPTH-1, the block moves to RUN and busy is cleared.
  - In RUN the block stays in RUN until the next rst.
- **Request gating.** A request is accepted only on an edge where busy == 0. wr_en and rd_en asserted during INIT are dropped silently.
- **Read-during-write, same address, same edge.** The read returns the old value (read-first), including the LVT selection.
- **Idle read ports.** When rd_en[r] is low, rd_data[r] holds its previous value and rd_valid[r] = 0.
- **Reset mid-operation.** The sweep restarts from address 0. Data written before the reset is lost because the LVT points every address to the zeroed bank 0.

## Timing
- Reset values: busy = 1, rd_data = 0 (all ports), rd_valid = 0, init_cnt = 0, state = INIT.
- busy falls after exactly DEPTH rising edges following rst deassertion. The first request can be accepted on edge DEPTH+1.
- Read latency is 1 cycle. The address is sampled on edge N; rd_data and rd_valid are valid after edge N and persist until edge N+1.
- A write accepted on edge N is visible to a read sampled on edge N+1 or later.
- Throughput is one read per read port and one write per write port every cycle, with no stalls in RUN.
- The LVT read and the bank read are registered on the same edge, so no extra pipeline stage is introduced.

## Configuration
- **LVT_MPRAM_BYPASS_EN**
  - Defined: write-to-read forwarding is enabled. A read sampled on the same edge as an accepted write to the same address returns the new data. If several ports write that address, the highest-index writer's data is returned. Latency is unchanged.
  - Undefined: read-first behaviour as described in Operation, with no forwarding logic.

## Test plan
All cases use default parameters (DATA_W=32, ADDR_W=7, NW=2, NR=2).
- **Init sweep:** release rst, assert rd_en[0] at addr 5 throughout → busy stays 1 for 128 edges and rd_valid stays 0. After busy falls, a read of addr 5 returns 0x0 with rd_valid[0] = 1 one cycle later.
- **Basic write/read:** port 0 writes 0xA5A5_0001 to addr 3; next cycle port 1 writes 0x1234_5678 to addr 3; then rd0 and rd1 both read addr 3 → both return 0x1234_5678.
- **Conflict:** port 0 writes 0x1111_1111 and port 1 writes 0x2222_2222 to addr 10 on the same edge → a subsequent read on both ports returns 0x2222_2222.
- **Read-during-write:** addr 20 holds 0xDEAD_BEEF; on one edge, port 0 writes 0xCAFE_F00D to addr 20 while rd0 reads addr 20 → returns 0xDEAD_BEEF without the macro, 0xCAFE_F00D with LVT_MPRAM_BYPASS_EN. The next read returns 0xCAFE_F00D in both builds.
- **Reset mid-run:** write 0x5555_5555 to addr 127, assert rst during RUN, then read addr 127 after busy falls → returns 0x0. Requests issued during the sweep do not alter memory.
- **Idle hold:** read addr 3 (value 0x1234_5678), then deassert rd_en[0] for 4 cycles → rd_data[0] holds 0x1234_5678 and rd_valid[0] = 0.

Source files
------------

// File: rtl/lvt_mpram.sv
// lvt_mpram: multiported RAM with NW write ports and NR read ports, built from
// NW x NR simple-dual-port bank replicas plus a Live Value Table that records,
// per address, which write port last wrote it. After reset an INIT sweep zeroes
// bank 0 and the LVT; requests are ignored while busy is high.
// Optional build macro: LVT_MPRAM_BYPASS_EN enables same-edge write-to-read
// forwarding (newest data wins); without it reads are read-first.
module lvt_mpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int NW     = 2,
  parameter int NR     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   busy,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW*ADDR_W-1:0]   wr_addr,
  input  logic [NW*DATA_W-1:0]   wr_data,
  input  logic [NR-1:0]          rd_en,
  input  logic [NR*ADDR_W-1:0]   rd_addr,
  output logic [NR*DATA_W-1:0]   rd_data,
  output logic [NR-1:0]          rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LVT_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;

  logic [NW-1:0]       wr_acc;
  logic [NR-1:0]       rd_acc;

  logic [DATA_W-1:0]   bank_q [NW][NR][DEPTH];
  logic [LVT_W-1:0]    lvt_q  [DEPTH];

  logic [DATA_W-1:0]   rd_d   [NR];
  logic [DATA_W-1:0]   rd_q   [NR];
  logic [NR-1:0]       rd_valid_q;

  assign busy   = (state_q == INIT);
  assign wr_acc = busy ? '0 : wr_en;
  assign rd_acc = busy ? '0 : rd_en;

  // Control state register: reset restarts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state: walk every address once, then stay in RUN until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  // Bank replicas: each write port updates all of its NR copies; the sweep zeroes bank 0.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        if (wr_acc[w]) begin
          bank_q[w][r][wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
    if (state_q == INIT) begin
      for (int r = 0; r < NR; r++) begin
        bank_q[0][r][init_cnt_q] <= '0;
      end
    end
  end

  // LVT update: ascending loop so the highest-index writer of an address wins.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      lvt_q[init_cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_acc[w]) begin
          lvt_q[wr_addr[w*ADDR_W +: ADDR_W]] <= LVT_W'(w);
        end
      end
    end
  end

  // Read selection: pick the replica named by the LVT, optionally forwarding same-edge writes.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rd_d[r] = bank_q[lvt_q[rd_addr[r*ADDR_W +: ADDR_W]]][r][rd_addr[r*ADDR_W +: ADDR_W]];
`ifdef LVT_MPRAM_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (wr_acc[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
          rd_d[r] = wr_data[w*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  // Read output register: idle ports hold their data and drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        rd_q[r] <= '0;
      end
      rd_valid_q <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (rd_acc[r]) begin
          rd_q[r] <= rd_d[r];
        end
      end
      rd_valid_q <= rd_acc;
    end
  end

  // Flatten per-port read data onto the output vector.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NR; r++) begin
      rd_data[r*DATA_W +: DATA_W] = rd_q[r];
    end
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lvt_mpram.sv
// tb_lvt_mpram: randomized and directed bench for lvt_mpram against a flat
// "latest value per address" memory model.
module tb_lvt_mpram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int NW     = 2;
  localparam int NR     = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  busy;
  logic [NW-1:0]         wr_en;
  logic [NW*ADDR_W-1:0]  wr_addr;
  logic [NW*DATA_W-1:0]  wr_data;
  logic [NR-1:0]         rd_en;
  logic [NR*ADDR_W-1:0]  rd_addr;
  logic [NR*DATA_W-1:0]  rd_data;
  logic [NR-1:0]         rd_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model: current contents seen by any reader, plus expected outputs.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_rd  [NR];
  logic              exp_vld [NR];
  int                init_left;

  always #5 clk = ~clk;

  lvt_mpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NW(NW), .NR(NR)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic set_wr(input int p, input logic en, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    wr_en[p]                   = en;
    wr_addr[p*ADDR_W +: ADDR_W] = a;
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [ADDR_W-1:0] a);
    rd_en[p]                   = en;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_inputs();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
  endtask

  task automatic model_reads();
    for (int r = 0; r < NR; r++) begin
      if (rd_en[r]) begin
        exp_rd[r]  = ref_mem[rd_addr[r*ADDR_W +: ADDR_W]];
        exp_vld[r] = 1'b1;
      end else begin
        exp_vld[r] = 1'b0;
      end
    end
  endtask

  // Advance one clock edge, updating the model from the inputs presented.
  task automatic cycle();
    if (init_left > 0) begin
      init_left--;
      for (int r = 0; r < NR; r++) exp_vld[r] = 1'b0;
    end else begin
`ifndef LVT_MPRAM_BYPASS_EN
      model_reads();
`endif
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w]) ref_mem[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
      end
`ifdef LVT_MPRAM_BYPASS_EN
      model_reads();
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously mid-cycle, then release it just after an edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    init_left = DEPTH;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int r = 0; r < NR; r++) begin
      exp_rd[r]  = '0;
      exp_vld[r] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=1", busy);
    end
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h exp=0", rd_data);
    end
    checks++;
    if (rd_valid !== '0) begin
      failures++;
      $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
    end
    do_reset();
  endtask

  task automatic test_init_sweep();
    idle_inputs();
    set_rd(0, 1'b1, 7'd5);
    for (int e = 1; e <= DEPTH; e++) begin
      cycle();
      checks++;
      if (busy !== (e < DEPTH)) begin
        failures++;
        $display("FAIL sweep_busy edge=%0d got=%b exp=%b", e, busy, (e < DEPTH));
      end
      checks++;
      if (rd_valid !== '0) begin
        failures++;
        $display("FAIL sweep_rd_valid edge=%0d got=%b exp=0", e, rd_valid);
      end
    end
    cycle();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[DATA_W-1:0] !== 32'h0) begin
      failures++;
      $display("FAIL sweep_first_read got=%h/%b exp=00000000/1", rd_data[DATA_W-1:0], rd_valid[0]);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    set_wr(0, 1'b1, 7'd3, 32'hA5A5_0001);
    cycle();
    idle_inputs();
    set_wr(1, 1'b1, 7'd3, 32'h1234_5678);
    cycle();
    idle_inputs();
    set_rd(0, 1'b1, 7'd3);
    set_rd(1, 1'b1, 7'd3);
    cycle();
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (rd_data[r*DATA_W +: DATA_W] !== 32'h1234_5678 || rd_valid[r] !== 1'b1) begin
        failures++;
        $display("FAIL basic_rd%0d got=%h/%b exp=12345678/1", r, rd_data[r*DATA_W +: DATA_W], rd_valid[r]);
      end
    end
  endtask

  task automatic test_conflict();
    idle_inputs();
    set_wr(0, 1'b1, 7'd10, 32'h1111_1111);
    set_wr(1, 1'b1, 7'd10, 32'h2222_2222);
    cycle();
    idle_inputs();
    set_rd(0, 1'b1, 7'd10);
    set_rd(1, 1'b1, 7'd10);
    cycle();
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (rd_data[r*DATA_W +: DATA_W] !== 32'h2222_2222 || rd_valid[r] !== 1'b1) begin
        failures++;
        $display("FAIL conflict_rd%0d got=%h/%b exp=22222222/1", r, rd_data[r*DATA_W +: DATA_W], rd_valid[r]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [DATA_W-1:0] first_exp;
`ifdef LVT_MPRAM_BYPASS_EN
    first_exp = 32'hCAFE_F00D;
`else
    first_exp = 32'hDEAD_BEEF;
`endif
    idle_inputs();
    set_wr(1, 1'b1, 7'd20, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    set_wr(0, 1'b1, 7'd20, 32'hCAFE_F00D);
    set_rd(0, 1'b1, 7'd20);
    cycle();
    checks++;
    if (rd_data[DATA_W-1:0] !== first_exp || rd_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL rdw_same_edge got=%h/%b exp=%h/1", rd_data[DATA_W-1:0], rd_valid[0], first_exp);
    end
    idle_inputs();
    set_rd(0, 1'b1, 7'd20);
    cycle();
    checks++;
    if (rd_data[DATA_W-1:0] !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL rdw_next got=%h exp=cafef00d", rd_data[DATA_W-1:0]);
    end
  endtask

  task automatic test_idle_hold();
    idle_inputs();
    set_rd(0, 1'b1, 7'd3);
    cycle();
    checks++;
    if (rd_data[DATA_W-1:0] !== 32'h1234_5678 || rd_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL idle_first got=%h/%b exp=12345678/1", rd_data[DATA_W-1:0], rd_valid[0]);
    end
    idle_inputs();
    set_rd(0, 1'b0, 7'd40);
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (rd_data[DATA_W-1:0] !== 32'h1234_5678 || rd_valid[0] !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h/%b exp=12345678/0", k, rd_data[DATA_W-1:0], rd_valid[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < NW; w++) begin
        set_wr(w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7)),
               DATA_W'($urandom));
      end
      for (int r = 0; r < NR; r++) begin
        set_rd(r, 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7)));
      end
      cycle();
      for (int r = 0; r < NR; r++) begin
        checks++;
        if (rd_valid[r] !== exp_vld[r] || rd_data[r*DATA_W +: DATA_W] !== exp_rd[r]) begin
          failures++;
          $display("FAIL random n=%0d rd%0d got=%h/%b exp=%h/%b", n, r,
                   rd_data[r*DATA_W +: DATA_W], rd_valid[r], exp_rd[r], exp_vld[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    set_wr(0, 1'b1, 7'd127, 32'h5555_5555);
    cycle();
    idle_inputs();
    do_reset();
    for (int e = 1; e <= DEPTH; e++) begin
      for (int w = 0; w < NW; w++) set_wr(w, 1'b1, ADDR_W'($urandom_range(120, 127)), DATA_W'($urandom));
      for (int r = 0; r < NR; r++) set_rd(r, 1'b1, ADDR_W'($urandom));
      cycle();
      checks++;
      if (busy !== (e < DEPTH) || rd_valid !== '0) begin
        failures++;
        $display("FAIL midrst_sweep edge=%0d got=%b/%b exp=%b/00", e, busy, rd_valid, (e < DEPTH));
      end
    end
    idle_inputs();
    set_rd(0, 1'b1, 7'd127);
    set_rd(1, 1'b1, 7'd121);
    cycle();
    checks++;
    if (rd_data[DATA_W-1:0] !== 32'h0 || rd_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_addr127 got=%h/%b exp=00000000/1", rd_data[DATA_W-1:0], rd_valid[0]);
    end
    checks++;
    if (rd_data[DATA_W +: DATA_W] !== 32'h0 || rd_valid[1] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_addr121 got=%h/%b exp=00000000/1", rd_data[DATA_W +: DATA_W], rd_valid[1]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    init_left = DEPTH;
    idle_inputs();
    test_reset();
    test_init_sweep();
    test_basic();
    test_conflict();
    test_read_during_write();
    test_idle_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
